// File: rtl/zero_indices_collect.sv
// zero_indices_collect: buffers the zero indices reported by the scanner in
// a small FIFO, re-presents them on a valid/accept handshake, and emits a
// per-scan summary (zero count, overflow) once the scan has ended and the
// FIFO has drained.
module zero_indices_collect #(
    parameter int W     = 128,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   scan_busy_r,
    input  logic                   scan_resp_valid_r,
    input  logic [$clog2(W)-1:0]   scan_resp_index_r,
    output logic                   out_valid_r,
    output logic [$clog2(W)-1:0]   out_index_r,
    input  logic                   out_accept,
    output logic                   done_r,
    output logic [$clog2(W):0]     done_count_r,
    output logic                   done_ovf_r
);

    localparam int IW = $clog2(W);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_TAIL  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t         st_r;
    state_t         st_nxt_s;
    logic           busy_q;
    logic           rise_s;
    logic           fall_s;
    logic           clear_s;
    logic           done_s;

    logic [IW:0]    cnt_r;
    logic [IW:0]    cnt_nxt_s;
    logic           ovf_r;
    logic           ovf_nxt_s;

    logic [IW-1:0]  mem_r [DEPTH];
    logic [AW:0]    wr_ptr_r;
    logic [AW:0]    rd_ptr_r;
    logic [AW:0]    wr_ptr_nxt_s;
    logic [AW:0]    rd_ptr_nxt_s;
    logic           full_s;
    logic           push_s;
    logic           pop_s;
    logic           drop_s;
    logic           next_empty_s;
    logic [IW-1:0]  head_s;

    // Busy edge detection against the previous cycle's busy flag.
    always_comb begin
        rise_s = scan_busy_r & ~busy_q;
        fall_s = ~scan_busy_r & busy_q;
    end

    // FIFO control: push/pop/drop decisions and next pointer values. The
    // wrap bit distinguishes full from empty when the low bits match.
    always_comb begin
        full_s       = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                       (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
        pop_s        = out_valid_r & out_accept;
        push_s       = scan_resp_valid_r & (~full_s | pop_s);
        drop_s       = scan_resp_valid_r & full_s & ~pop_s;
        wr_ptr_nxt_s = wr_ptr_r + {{AW{1'b0}}, push_s};
        rd_ptr_nxt_s = rd_ptr_r + {{AW{1'b0}}, pop_s};
        next_empty_s = (wr_ptr_nxt_s == rd_ptr_nxt_s);
    end

    // Next head value: the incoming index when it lands in the slot that
    // becomes the head (FIFO was empty or is emptying), else stored data.
    always_comb begin
        head_s = mem_r[rd_ptr_nxt_s[AW-1:0]];
        if (push_s && (wr_ptr_r[AW-1:0] == rd_ptr_nxt_s[AW-1:0])) begin
            head_s = scan_resp_index_r;
        end else begin
            head_s = mem_r[rd_ptr_nxt_s[AW-1:0]];
        end
    end

    // FIFO storage write; contents are meaningless while the pointers say empty.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= scan_resp_index_r;
        end
    end

    // FIFO pointers and the registered head presentation.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_r    <= {(AW+1){1'b0}};
            rd_ptr_r    <= {(AW+1){1'b0}};
            out_valid_r <= 1'b0;
            out_index_r <= {IW{1'b0}};
        end else begin
            wr_ptr_r    <= wr_ptr_nxt_s;
            rd_ptr_r    <= rd_ptr_nxt_s;
            out_valid_r <= ~next_empty_s;
            if (!next_empty_s) begin
                out_index_r <= head_s;
            end
        end
    end

    // Scan-tracking FSM: next state, summary pulse request and counter clear.
    always_comb begin
        st_nxt_s = st_r;
        clear_s  = 1'b0;
        done_s   = 1'b0;
        case (st_r)
            ST_IDLE: begin
                if (rise_s) begin
                    clear_s  = 1'b1;
                    st_nxt_s = ST_SCAN;
                end else begin
                    st_nxt_s = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (fall_s) begin
                    st_nxt_s = ST_TAIL;
                end else begin
                    st_nxt_s = ST_SCAN;
                end
            end
            ST_TAIL: begin
                if (rise_s) begin
                    done_s   = 1'b1;
                    clear_s  = 1'b1;
                    st_nxt_s = ST_SCAN;
                end else begin
                    st_nxt_s = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (rise_s) begin
                    done_s   = 1'b1;
                    clear_s  = 1'b1;
                    st_nxt_s = ST_SCAN;
                end else if (!out_valid_r) begin
                    done_s   = 1'b1;
                    st_nxt_s = ST_IDLE;
                end else begin
                    st_nxt_s = ST_DRAIN;
                end
            end
            default: begin
                st_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Per-scan zero count and sticky overflow; a clear still accounts for
    // a response or drop arriving in the clearing cycle.
    always_comb begin
        cnt_nxt_s = cnt_r;
        ovf_nxt_s = ovf_r;
        if (clear_s) begin
            cnt_nxt_s = {{IW{1'b0}}, scan_resp_valid_r};
            ovf_nxt_s = drop_s;
        end else begin
            cnt_nxt_s = cnt_r + {{IW{1'b0}}, scan_resp_valid_r};
            ovf_nxt_s = ovf_r | drop_s;
        end
    end

    // State, busy history and per-scan statistics registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            st_r   <= ST_IDLE;
            busy_q <= 1'b0;
            cnt_r  <= {(IW+1){1'b0}};
            ovf_r  <= 1'b0;
        end else begin
            st_r   <= st_nxt_s;
            busy_q <= scan_busy_r;
            cnt_r  <= cnt_nxt_s;
            ovf_r  <= ovf_nxt_s;
        end
    end

    // Summary outputs: one-cycle pulse with the finished scan's statistics held.
    always_ff @(posedge clk) begin
        if (!rst) begin
            done_r       <= 1'b0;
            done_count_r <= {(IW+1){1'b0}};
            done_ovf_r   <= 1'b0;
        end else begin
            done_r <= done_s;
            if (done_s) begin
                done_count_r <= cnt_r;
                done_ovf_r   <= ovf_r;
            end
        end
    end

endmodule

// File: tb/tb_zero_indices_collect.sv
// Directed testbench for zero_indices_collect (W=128, DEPTH=8).
module tb_zero_indices_collect;

    logic       clk = 1'b0;
    logic       rst;
    logic       busy;
    logic       valid;
    logic [6:0] idx;
    logic       acc;
    logic       out_valid_r;
    logic [6:0] out_index_r;
    logic       done_r;
    logic [7:0] done_count_r;
    logic       done_ovf_r;

    int tests  = 0;
    int failed = 0;
    int exp_q[$];

    typedef struct {
        logic       busy;
        logic       valid;
        logic [6:0] idx;
        logic       acc;
        logic       e_ov;
        logic [6:0] e_idx;
        logic       e_done;
        logic [7:0] e_cnt;
        logic       e_ovf;
    } vec_t;

    vec_t vecs[15];

    zero_indices_collect #(.W(128), .DEPTH(8)) dut (
        .clk               (clk),
        .rst               (rst),
        .scan_busy_r       (busy),
        .scan_resp_valid_r (valid),
        .scan_resp_index_r (idx),
        .out_valid_r       (out_valid_r),
        .out_index_r       (out_index_r),
        .out_accept        (acc),
        .done_r            (done_r),
        .done_count_r      (done_count_r),
        .done_ovf_r        (done_ovf_r)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        tests++;
        if (act !== exp_v) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic b, input logic v, input logic [6:0] i, input logic a);
        busy  = b;
        valid = v;
        idx   = i;
        acc   = a;
    endtask

    // End the scan, accept everything and compare against exp_q and the summary.
    task automatic drain_collect(input string nm, input int exp_cnt, input int exp_ovf);
        int k = 0;
        bit seen = 1'b0;
        drive(1'b0, 1'b0, 7'd0, 1'b1);
        for (int c = 0; c < 40 && !seen; c++) begin
            if (out_valid_r) begin
                if (k < exp_q.size()) begin
                    check({nm, " order"}, 32'(out_index_r), 32'(exp_q[k]));
                end else begin
                    check({nm, " extra entry"}, 32'(out_index_r), 32'd999);
                end
                k++;
            end
            tick();
            if (done_r) begin
                seen = 1'b1;
                check({nm, " count"}, 32'(done_count_r), 32'(exp_cnt));
                check({nm, " ovf"}, 32'(done_ovf_r), 32'(exp_ovf));
                check({nm, " delivered"}, 32'(k), 32'(exp_q.size()));
            end
        end
        if (!seen) begin
            check({nm, " done timeout"}, 32'd0, 32'd1);
        end
        drive(1'b0, 1'b0, 7'd0, 1'b0);
        tick();
        check({nm, " done single pulse"}, 32'(done_r), 32'd0);
    endtask

    initial begin
        // Single zero at 37, then an all-ones scan (no responses).
        vecs[0]  = '{1'b1, 1'b0, 7'd0,  1'b1, 1'b0, 7'd0,  1'b0, 8'd0, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 7'd37, 1'b1, 1'b1, 7'd37, 1'b0, 8'd0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 7'd0,  1'b1, 1'b0, 7'd0,  1'b0, 8'd0, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 7'd0,  1'b1, 1'b0, 7'd0,  1'b0, 8'd0, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 7'd0,  1'b1, 1'b0, 7'd0,  1'b0, 8'd0, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 7'd0,  1'b1, 1'b0, 7'd0,  1'b0, 8'd0, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 7'd0,  1'b1, 1'b0, 7'd0,  1'b1, 8'd1, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 7'd0,  1'b1, 1'b0, 7'd0,  1'b0, 8'd1, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 7'd0,  1'b1, 1'b0, 7'd0,  1'b0, 8'd1, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 7'd0,  1'b1, 1'b0, 7'd0,  1'b0, 8'd1, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 7'd0,  1'b1, 1'b0, 7'd0,  1'b0, 8'd1, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 7'd0,  1'b1, 1'b0, 7'd0,  1'b0, 8'd1, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 7'd0,  1'b1, 1'b0, 7'd0,  1'b0, 8'd1, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 7'd0,  1'b1, 1'b0, 7'd0,  1'b1, 8'd0, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 7'd0,  1'b1, 1'b0, 7'd0,  1'b0, 8'd0, 1'b0};

        // Reset.
        rst = 1'b0;
        drive(1'b0, 1'b0, 7'd0, 1'b0);
        tick();
        tick();
        check("reset out_valid", 32'(out_valid_r), 32'd0);
        check("reset out_index", 32'(out_index_r), 32'd0);
        check("reset done", 32'(done_r), 32'd0);
        check("reset count", 32'(done_count_r), 32'd0);
        check("reset ovf", 32'(done_ovf_r), 32'd0);
        rst = 1'b1;
        tick();

        // Table: single zero, then empty scan.
        for (int v = 0; v < 15; v++) begin
            drive(vecs[v].busy, vecs[v].valid, vecs[v].idx, vecs[v].acc);
            tick();
            check($sformatf("vec%0d out_valid", v), 32'(out_valid_r), 32'(vecs[v].e_ov));
            if (vecs[v].e_ov) begin
                check($sformatf("vec%0d out_index", v), 32'(out_index_r), 32'(vecs[v].e_idx));
            end
            check($sformatf("vec%0d done", v), 32'(done_r), 32'(vecs[v].e_done));
            check($sformatf("vec%0d count", v), 32'(done_count_r), 32'(vecs[v].e_cnt));
            check($sformatf("vec%0d ovf", v), 32'(done_ovf_r), 32'(vecs[v].e_ovf));
        end

        // Overflow: indices 0..11 with no accepts, 8..11 dropped.
        drive(1'b1, 1'b0, 7'd0, 1'b0);
        tick();
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, 1'b1, 7'(i), 1'b0);
            tick();
        end
        check("ovf head valid", 32'(out_valid_r), 32'd1);
        check("ovf head index", 32'(out_index_r), 32'd0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 7'd0, 1'b0);
            tick();
            check("ovf hold index", 32'(out_index_r), 32'd0);
            check("ovf early done", 32'(done_r), 32'd0);
        end
        for (int i = 0; i < 8; i++) begin
            check("ovf drain valid", 32'(out_valid_r), 32'd1);
            check("ovf drain index", 32'(out_index_r), 32'(i));
            drive(1'b0, 1'b0, 7'd0, 1'b1);
            tick();
            check("ovf done before drained", 32'(done_r), 32'd0);
        end
        check("ovf empty after 8", 32'(out_valid_r), 32'd0);
        drive(1'b0, 1'b0, 7'd0, 1'b0);
        tick();
        check("ovf done", 32'(done_r), 32'd1);
        check("ovf count", 32'(done_count_r), 32'd12);
        check("ovf flag", 32'(done_ovf_r), 32'd1);
        tick();
        check("ovf done single", 32'(done_r), 32'd0);

        // Full FIFO with push and pop in the same cycle: nothing dropped.
        drive(1'b1, 1'b0, 7'd0, 1'b0);
        tick();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b1, 7'(20 + i), 1'b0);
            tick();
        end
        check("full head", 32'(out_index_r), 32'd20);
        drive(1'b1, 1'b1, 7'd28, 1'b1);
        tick();
        check("full pop-push head", 32'(out_index_r), 32'd21);
        exp_q = {};
        for (int i = 21; i <= 28; i++) exp_q.push_back(i);
        drain_collect("full", 9, 0);

        // New scan during DRAIN with 3 entries pending.
        drive(1'b1, 1'b0, 7'd0, 1'b0);
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, 7'(40 + i), 1'b0);
            tick();
        end
        drive(1'b0, 1'b0, 7'd0, 1'b0);
        tick();
        tick();
        check("rescan head0", 32'(out_index_r), 32'd40);
        drive(1'b0, 1'b0, 7'd0, 1'b1);
        tick();
        check("rescan head1", 32'(out_index_r), 32'd41);
        tick();
        check("rescan head2", 32'(out_index_r), 32'd42);
        check("rescan no early done", 32'(done_r), 32'd0);
        drive(1'b1, 1'b0, 7'd0, 1'b0);
        tick();
        check("rescan done", 32'(done_r), 32'd1);
        check("rescan count", 32'(done_count_r), 32'd5);
        check("rescan ovf", 32'(done_ovf_r), 32'd0);
        check("rescan retained", 32'(out_index_r), 32'd42);
        drive(1'b1, 1'b1, 7'd50, 1'b0);
        tick();
        check("rescan done single", 32'(done_r), 32'd0);
        drive(1'b1, 1'b1, 7'd51, 1'b0);
        tick();
        exp_q = '{42, 43, 44, 50, 51};
        drain_collect("rescan second", 2, 0);

        // Reset mid-scan with 5 buffered entries.
        drive(1'b1, 1'b0, 7'd0, 1'b0);
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, 7'(60 + i), 1'b0);
            tick();
        end
        check("midrst buffered", 32'(out_valid_r), 32'd1);
        rst = 1'b0;
        drive(1'b1, 1'b0, 7'd0, 1'b0);
        tick();
        check("midrst out_valid", 32'(out_valid_r), 32'd0);
        check("midrst out_index", 32'(out_index_r), 32'd0);
        check("midrst done", 32'(done_r), 32'd0);
        check("midrst count", 32'(done_count_r), 32'd0);
        check("midrst ovf", 32'(done_ovf_r), 32'd0);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, 7'd0, 1'b1);
            tick();
            check("midrst quiet done", 32'(done_r), 32'd0);
            check("midrst quiet valid", 32'(out_valid_r), 32'd0);
        end
        drive(1'b1, 1'b0, 7'd0, 1'b0);
        tick();
        drive(1'b1, 1'b1, 7'd70, 1'b0);
        tick();
        exp_q = '{70};
        drain_collect("after reset", 1, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
